// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath.
// The multiplier and the reduction stage both use these widths and types.
package rsa_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [WIDTH:0]   hword_t;
endpackage

// File: rtl/rsa_mult.sv
// Radix-2 shift-add multiplier: P = A*B in WIDTH cycles, presented as {Hreg, Lreg}.
// mod_go is a level that holds the downstream reduction stage until the product is valid.
module rsa_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH,
  parameter int CNT_W = rsa_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             mod_go,
  output logic [WIDTH:0]   Hreg,
  output logic [WIDTH-1:0] Lreg
);

  // Handshake: start is honoured on a rising clk only in IDLE or DONE; A/B are
  // captured on that same edge. done pulses for one cycle when Hreg/Lreg update,
  // and mod_go stays high (outputs frozen) until the next accepted start or rst.

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [WIDTH:0]     hi, hi_n;
  logic [WIDTH-1:0]   lo, lo_n;
  logic [WIDTH:0]     hreg_n;
  logic [WIDTH-1:0]   lreg_n;
  logic               busy_n, done_n, go_n;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      Hreg   <= '0;
      Lreg   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mod_go <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mcand  <= mcand_n;
      hi     <= hi_n;
      lo     <= lo_n;
      Hreg   <= hreg_n;
      Lreg   <= lreg_n;
      busy   <= busy_n;
      done   <= done_n;
      mod_go <= go_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mcand_n = mcand;
    hi_n    = hi;
    lo_n    = lo;
    hreg_n  = Hreg;
    lreg_n  = Lreg;
    busy_n  = busy;
    done_n  = 1'b0;
    go_n    = mod_go;
    // hi stays below 2**WIDTH between steps, so the extra bit only ever holds the carry
    sum     = hi + (lo[0] ? {1'b0, mcand} : '0);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          mcand_n = A;
          lo_n    = B;
          hi_n    = '0;
          cnt_n   = CNT_W'(WIDTH);
          busy_n  = 1'b1;
          go_n    = 1'b0;
          state_n = RUN;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        hi_n  = {1'b0, sum[WIDTH:1]};
        lo_n  = {sum[0], lo[WIDTH-1:1]};
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hreg_n  = hi_n;
          lreg_n  = lo_n;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          go_n    = 1'b1;
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        go_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_mult.sv
// Directed bench for rsa_mult: hand-computed products, latency, start-ignore,
// back-to-back restart and asynchronous reset in mid-operation.
module tb_rsa_mult;
  import rsa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  word_t       A, B;
  logic        busy, done, mod_go;
  hword_t      Hreg;
  word_t       Lreg;

  int vectors = 0;
  int errors  = 0;

  rsa_mult dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .mod_go (mod_go),
    .Hreg   (Hreg),
    .Lreg   (Lreg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the accepting rising edge.
  task automatic start_op(input word_t a, input word_t b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the falling edge after acceptance; returns at the falling edge where done is seen.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) busy_cycles++;
    end
  endtask

  int lat, bcy, npulse;
  logic held_ok;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_mod_go", 32'(mod_go), 32'd0);
    chk("rst_hreg",   32'(Hreg),   32'd0);
    chk("rst_lreg",   32'(Lreg),   32'd0);
    rst = 1'b0;

    // 13 * 11 = 143
    start_op(8'd13, 8'd11);
    chk("t1_busy_on", 32'(busy), 32'd1);
    wait_done(lat, bcy);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_busy_cycles", 32'(bcy), 32'd8);
    chk("t1_hreg", 32'(Hreg), 32'h000);
    chk("t1_lreg", 32'(Lreg), 32'h8F);
    chk("t1_mod_go", 32'(mod_go), 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_mod_go_held", 32'(mod_go), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_mod_go_idle", 32'(mod_go), 32'd1);
    chk("t1_lreg_held", 32'(Lreg), 32'h8F);

    // max operands: 0xFF * 0xFF = 0xFE01
    start_op(8'hFF, 8'hFF);
    wait_done(lat, bcy);
    chk("t2_latency", 32'(lat), 32'd8);
    chk("t2_hreg", 32'(Hreg), 32'h0FE);
    chk("t2_lreg", 32'(Lreg), 32'h01);
    chk("t2_hmsb", 32'(Hreg[8]), 32'd0);

    // back-to-back: start sampled in the DONE cycle
    A = 8'h10;
    B = 8'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_mod_go_fall", 32'(mod_go), 32'd0);
    chk("t3_done_low", 32'(done), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    held_ok = (Hreg === 9'h0FE) && (Lreg === 8'h01);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (Hreg !== 9'h0FE || Lreg !== 8'h01) held_ok = 1'b0;
    end
    chk("t3_old_held", 32'(held_ok), 32'd1);
    chk("t3_latency", 32'(lat), 32'd8);
    chk("t3_hreg", 32'(Hreg), 32'h001);
    chk("t3_lreg", 32'(Lreg), 32'h00);

    // zero operand: no early exit
    start_op(8'h00, 8'h5A);
    wait_done(lat, bcy);
    chk("t4_latency", 32'(lat), 32'd8);
    chk("t4_hreg", 32'(Hreg), 32'h000);
    chk("t4_lreg", 32'(Lreg), 32'h00);
    start_op(8'h01, 8'h80);
    wait_done(lat, bcy);
    chk("t4b_latency", 32'(lat), 32'd8);
    chk("t4b_hreg", 32'(Hreg), 32'h000);
    chk("t4b_lreg", 32'(Lreg), 32'h80);

    // start re-pulsed during RUN is ignored: 3 * 5 = 15
    start_op(8'd3, 8'd5);
    repeat (2) @(negedge clk);
    A = 8'h02;
    B = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("t5_latency", 32'(lat), 32'd5);
    chk("t5_hreg", 32'(Hreg), 32'h000);
    chk("t5_lreg", 32'(Lreg), 32'h0F);
    repeat (12) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("t5_single_done", 32'(npulse), 32'd0);
    chk("t5_lreg_after", 32'(Lreg), 32'h0F);

    // asynchronous reset in mid-operation
    start_op(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_mod_go", 32'(mod_go), 32'd0);
    chk("t6_hreg", 32'(Hreg), 32'd0);
    chk("t6_lreg", 32'(Lreg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_no_done", 32'(mod_go), 32'd0);
    start_op(8'd13, 8'd11);
    wait_done(lat, bcy);
    chk("t6_fresh_latency", 32'(lat), 32'd8);
    chk("t6_fresh_hreg", 32'(Hreg), 32'h000);
    chk("t6_fresh_lreg", 32'(Lreg), 32'h8F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
